// File: rtl/perf_counters.sv
// perf_counters: bank of five 64-bit event counters (cycle, retired,
// flush, wait, decoded). Each count is kept as two XLEN halves joined
// by a one-cycle pipelined carry. The low half is re-registered so
// that every {H, L} pair presented downstream is a value the full
// counter really held.
module perf_counters #(
    parameter int             XLEN    = 32,   // matches the core XLEN
    parameter logic [XLEN-1:0] INIT_LO = '0,
    parameter logic [XLEN-1:0] INIT_HI = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            ev_retire,
    input  logic            ev_flush,
    input  logic            ev_wait,
    input  logic            ev_decode,
    input  logic [4:0]      inhibit,
    input  logic            clear,
    output logic [XLEN-1:0] cycleL,
    output logic [XLEN-1:0] cycleH,
    output logic [XLEN-1:0] instructionsL,
    output logic [XLEN-1:0] instructionsH,
    output logic [XLEN-1:0] flushsL,
    output logic [XLEN-1:0] flushsH,
    output logic [XLEN-1:0] waitsL,
    output logic [XLEN-1:0] waitsH,
    output logic [XLEN-1:0] decodedL,
    output logic [XLEN-1:0] decodedH,
    output logic [4:0]      ovf
);

    localparam int N = 5;

    // Bit order shared with inhibit/ovf: cycle, instr, flush, wait, decod.
    logic [N-1:0] ev;
    logic [N-1:0] inc;

    // Stage 1 state: running low half and the carry it produced.
    logic [N-1:0][XLEN-1:0] lo_int_q, lo_int_d;
    logic [N-1:0]           c_pend_q, c_pend_d;

    // Stage 2 state: high half plus the low half delayed to line up.
    logic [N-1:0][XLEN-1:0] hi_int_q, hi_int_d;
    logic [N-1:0][XLEN-1:0] lo_out_q, lo_out_d;
    logic [N-1:0]           ovf_q, ovf_d;

    assign ev  = {ev_decode, ev_wait, ev_flush, ev_retire, 1'b1};
    assign inc = ev & ~inhibit;

    // Stage 1 next state: increment the low half and flag its wrap.
    always_comb begin
        lo_int_d = lo_int_q;
        c_pend_d = '0;
        for (int i = 0; i < N; i++) begin
            if (clear) begin
                lo_int_d[i] = '0;
            end else if (inc[i]) begin
                lo_int_d[i] = lo_int_q[i] + XLEN'(1);
                c_pend_d[i] = &lo_int_q[i];
            end
        end
    end

    // ---- stage 1 / stage 2 boundary ----

    // Stage 2 next state: absorb carry into the high half, realign the
    // low half, and latch a sticky flag when the full 64-bit value wraps.
    // Clear beats any carry still in flight.
    always_comb begin
        hi_int_d = hi_int_q;
        lo_out_d = lo_out_q;
        ovf_d    = ovf_q;
        for (int i = 0; i < N; i++) begin
            if (clear) begin
                hi_int_d[i] = '0;
                lo_out_d[i] = '0;
                ovf_d[i]    = 1'b0;
            end else begin
                hi_int_d[i] = hi_int_q[i] + XLEN'(c_pend_q[i]);
                lo_out_d[i] = lo_int_q[i];
                ovf_d[i]    = ovf_q[i] | (c_pend_q[i] & (&hi_int_q[i]));
            end
        end
    end

    // Counter state registers; reset drops any carry in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) begin
                lo_int_q[i] <= INIT_LO;
                lo_out_q[i] <= INIT_LO;
                hi_int_q[i] <= INIT_HI;
            end
            c_pend_q <= '0;
            ovf_q    <= '0;
        end else begin
            lo_int_q <= lo_int_d;
            c_pend_q <= c_pend_d;
            hi_int_q <= hi_int_d;
            lo_out_q <= lo_out_d;
            ovf_q    <= ovf_d;
        end
    end

    assign cycleL        = lo_out_q[0];
    assign cycleH        = hi_int_q[0];
    assign instructionsL = lo_out_q[1];
    assign instructionsH = hi_int_q[1];
    assign flushsL       = lo_out_q[2];
    assign flushsH       = hi_int_q[2];
    assign waitsL        = lo_out_q[3];
    assign waitsH        = hi_int_q[3];
    assign decodedL      = lo_out_q[4];
    assign decodedH      = hi_int_q[4];
    assign ovf           = ovf_q;

endmodule

// File: tb/tb_perf_counters.sv
// Directed bench for perf_counters. Four instances share one stimulus
// stream but use different reset values:
//   [0] defaults, [1] INIT_LO=FFFFFFFE, [2] INIT_LO=INIT_HI=FFFFFFFF,
//   [3] INIT_LO=FFFFFFFF.
module tb_perf_counters;

    logic        clk;
    logic        rst_n;
    logic        ev_retire, ev_flush, ev_wait, ev_decode;
    logic [4:0]  inhibit;
    logic        clear;

    logic [31:0] cL[4], cH[4], iL[4], iH[4], fL[4], fH[4];
    logic [31:0] wL[4], wH[4], dL[4], dH[4];
    logic [4:0]  ov[4];

    int errors = 0;
    int checks = 0;

    perf_counters #(.XLEN(32), .INIT_LO(32'h0), .INIT_HI(32'h0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .ev_retire(ev_retire), .ev_flush(ev_flush),
        .ev_wait(ev_wait), .ev_decode(ev_decode), .inhibit(inhibit), .clear(clear),
        .cycleL(cL[0]), .cycleH(cH[0]), .instructionsL(iL[0]), .instructionsH(iH[0]),
        .flushsL(fL[0]), .flushsH(fH[0]), .waitsL(wL[0]), .waitsH(wH[0]),
        .decodedL(dL[0]), .decodedH(dH[0]), .ovf(ov[0]));

    perf_counters #(.XLEN(32), .INIT_LO(32'hFFFF_FFFE), .INIT_HI(32'h0)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .ev_retire(ev_retire), .ev_flush(ev_flush),
        .ev_wait(ev_wait), .ev_decode(ev_decode), .inhibit(inhibit), .clear(clear),
        .cycleL(cL[1]), .cycleH(cH[1]), .instructionsL(iL[1]), .instructionsH(iH[1]),
        .flushsL(fL[1]), .flushsH(fH[1]), .waitsL(wL[1]), .waitsH(wH[1]),
        .decodedL(dL[1]), .decodedH(dH[1]), .ovf(ov[1]));

    perf_counters #(.XLEN(32), .INIT_LO(32'hFFFF_FFFF), .INIT_HI(32'hFFFF_FFFF)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .ev_retire(ev_retire), .ev_flush(ev_flush),
        .ev_wait(ev_wait), .ev_decode(ev_decode), .inhibit(inhibit), .clear(clear),
        .cycleL(cL[2]), .cycleH(cH[2]), .instructionsL(iL[2]), .instructionsH(iH[2]),
        .flushsL(fL[2]), .flushsH(fH[2]), .waitsL(wL[2]), .waitsH(wH[2]),
        .decodedL(dL[2]), .decodedH(dH[2]), .ovf(ov[2]));

    perf_counters #(.XLEN(32), .INIT_LO(32'hFFFF_FFFF), .INIT_HI(32'h0)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .ev_retire(ev_retire), .ev_flush(ev_flush),
        .ev_wait(ev_wait), .ev_decode(ev_decode), .inhibit(inhibit), .clear(clear),
        .cycleL(cL[3]), .cycleH(cH[3]), .instructionsL(iL[3]), .instructionsH(iH[3]),
        .flushsL(fL[3]), .flushsH(fH[3]), .waitsL(wL[3]), .waitsH(wH[3]),
        .decodedL(dL[3]), .decodedH(dH[3]), .ovf(ov[3]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One rising edge, then settle 1 ns before sampling/driving.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        ev_retire = 1'b0;
        ev_flush  = 1'b0;
        ev_wait   = 1'b0;
        ev_decode = 1'b0;
        inhibit   = 5'b0;
        clear     = 1'b0;

        // Reset held: everything at its reset value.
        step();
        step();
        chk("rst_cycle", {cH[0], cL[0]}, 64'h0);
        chk("rst_instr", {iH[0], iL[0]}, 64'h0);
        chk("rst_flush", {fH[0], fL[0]}, 64'h0);
        chk("rst_wait",  {wH[0], wL[0]}, 64'h0);
        chk("rst_decod", {dH[0], dL[0]}, 64'h0);
        chk("rst_ovf",   {59'd0, ov[0]}, 64'h0);
        chk("rst_init_lo", {cH[1], cL[1]}, 64'h0000_0000_FFFF_FFFE);

        // Coherent low-half wrap on the cycle counter of instance 1.
        rst_n = 1'b1;
        step();
        chk("wrap_0", {cH[1], cL[1]}, 64'h0000_0000_FFFF_FFFE);
        step();
        chk("wrap_1", {cH[1], cL[1]}, 64'h0000_0000_FFFF_FFFF);
        step();
        chk("wrap_2", {cH[1], cL[1]}, 64'h0000_0001_0000_0000);
        step();
        chk("wrap_3", {cH[1], cL[1]}, 64'h0000_0001_0000_0001);
        chk("cyc_ovf_sticky", {63'd0, ov[2][0]}, 64'h1);

        // Full 64-bit overflow on the wait counter of instance 2.
        ev_wait = 1'b1;
        step();
        chk("ovf_pre",      {wH[2], wL[2]}, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("ovf_pre_flag", {63'd0, ov[2][3]}, 64'h0);
        step();
        chk("ovf_wrap",      {wH[2], wL[2]}, 64'h0);
        chk("ovf_wrap_flag", {63'd0, ov[2][3]}, 64'h1);
        step();
        chk("ovf_cont1", {wH[2], wL[2]}, 64'h1);
        ev_wait = 1'b0;
        step();
        chk("ovf_cont2", {wH[2], wL[2]}, 64'h2);
        step();
        chk("ovf_hold",        {wH[2], wL[2]}, 64'h2);
        chk("ovf_sticky_flag", {63'd0, ov[2][3]}, 64'h1);

        // Inhibit raised while a carry is pending (instance 3, flush).
        ev_flush = 1'b1;
        step();
        chk("inh_pre", {fH[3], fL[3]}, 64'h0000_0000_FFFF_FFFF);
        inhibit = 5'b00100;
        step();
        chk("inh_carry", {fH[3], fL[3]}, 64'h0000_0001_0000_0000);
        step();
        chk("inh_frozen1", {fH[3], fL[3]}, 64'h0000_0001_0000_0000);
        step();
        chk("inh_frozen2", {fH[3], fL[3]}, 64'h0000_0001_0000_0000);
        chk("inh_no_ovf",  {63'd0, ov[3][2]}, 64'h0);
        ev_flush = 1'b0;
        inhibit  = 5'b0;

        // Asynchronous reset mid-run takes effect before the next edge.
        rst_n = 1'b0;
        #1;
        chk("arst_cycle0", {cH[0], cL[0]}, 64'h0);
        chk("arst_cycle2", {cH[2], cL[2]}, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("arst_wait2",  {wH[2], wL[2]}, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("arst_ovf2",   {59'd0, ov[2]}, 64'h0);
        chk("arst_flush3", {fH[3], fL[3]}, 64'h0000_0000_FFFF_FFFF);
        step();

        // Clear with all events high and carries pending.
        rst_n     = 1'b1;
        ev_retire = 1'b1;
        ev_flush  = 1'b1;
        ev_wait   = 1'b1;
        ev_decode = 1'b1;
        step();
        chk("clr_pre", {cH[2], cL[2]}, 64'hFFFF_FFFF_FFFF_FFFF);
        clear = 1'b1;
        step();
        chk("clr_cycle2", {cH[2], cL[2]}, 64'h0);
        chk("clr_wait2",  {wH[2], wL[2]}, 64'h0);
        chk("clr_ovf2",   {59'd0, ov[2]}, 64'h0);
        chk("clr_instr0", {iH[0], iL[0]}, 64'h0);
        chk("clr_cycle3", {cH[3], cL[3]}, 64'h0);
        clear     = 1'b0;
        ev_flush  = 1'b0;
        ev_wait   = 1'b0;
        ev_decode = 1'b0;
        ev_retire = 1'b1;
        step();
        ev_retire = 1'b0;
        chk("clr_ret_lat1", {iH[0], iL[0]}, 64'h0);
        step();
        chk("clr_ret_lat2", {iH[0], iL[0]}, 64'h1);
        chk("clr_cyc2_run", {cH[2], cL[2]}, 64'h1);
        chk("clr_cyc3_run", {cH[3], cL[3]}, 64'h1);
        chk("clr_ovf2_run", {59'd0, ov[2]}, 64'h0);

        // Single-event latency with the cycle counter inhibited.
        clear   = 1'b1;
        inhibit = 5'b00001;
        step();
        clear = 1'b0;
        step();
        chk("lat_cyc_idle", {cH[0], cL[0]}, 64'h0);
        ev_retire = 1'b1;
        ev_decode = 1'b1;
        step();
        ev_retire = 1'b0;
        chk("lat_instr_d1", {iH[0], iL[0]}, 64'h0);
        step();
        ev_decode = 1'b0;
        chk("lat_instr_d2", {iH[0], iL[0]}, 64'h1);
        chk("lat_decod_d2", {dH[0], dL[0]}, 64'h1);
        chk("lat_cyc_frz",  {cH[0], cL[0]}, 64'h0);
        step();
        chk("lat_instr_d3", {iH[0], iL[0]}, 64'h1);
        chk("lat_decod_d3", {dH[0], dL[0]}, 64'h2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
